// File: rtl/stack_unit.sv
// -----------------------------------------------------------------------------
// stack_unit
// Hardware LIFO stack for the accumulator datapath. It holds DEPTH words of
// WIDTH bits and keeps an address-style stack pointer for MAR formation. The
// pointer starts at SP_TOP when the stack is empty and moves down one step for
// each entry. There is also a push+pop "replace top" mode and sticky error
// flags.
//
// Optional feature macro: STACK_WATERMARK_EN
//   When this macro is defined, the block adds the hiwater output and the
//   high-water-mark logic.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high reset
//   push       in   1      push strobe (single cycle)
//   pop        in   1      pop strobe (single cycle)
//   din        in   WIDTH  data to push / replace
//   clr_err    in   1      clears overflow/underflow (and hiwater)
//   dout       out  WIDTH  registered top-of-stack (0 when empty)
//   sp         out  WIDTH  registered SP_TOP - count
//   count      out  CW     number of valid entries
//   empty      out  1      count == 0
//   full       out  1      count == DEPTH
//   overflow   out  1      sticky: a push was rejected because the stack was full
//   underflow  out  1      sticky: a pop was rejected because the stack was empty
//   hiwater    out  CW     (STACK_WATERMARK_EN) highest count since reset/clr_err
// -----------------------------------------------------------------------------
module stack_unit #(
  parameter int              WIDTH  = 8,
  parameter int              DEPTH  = 4,
  parameter logic [WIDTH-1:0] SP_TOP = 8'h68,
  localparam int             CW     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] sp,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
`ifdef STACK_WATERMARK_EN
  ,
  output logic [CW-1:0]    hiwater
`endif
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_sp;
  logic [WIDTH-1:0] r_dout;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_empty;
  logic             w_full;
  logic             w_push;      // a new entry is added
  logic             w_pop;       // the top entry is removed
  logic             w_repl;      // the top entry is overwritten in place
  logic             w_ovf_ev;
  logic             w_unf_ev;
  logic [AW-1:0]    w_top_idx;
  logic [AW-1:0]    w_below_idx;
  logic [AW-1:0]    w_wr_idx;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] w_sp_nxt;
  logic [WIDTH-1:0] w_dout_nxt;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);

  // With push+pop on an empty stack, the push is still performed. Only the pop
  // is rejected. DEPTH >= 2, so an empty stack can never be full at the same
  // time.
  assign w_push   = push && (pop ? w_empty : !w_full);
  assign w_pop    = pop && !push && !w_empty;
  assign w_repl   = push && pop && !w_empty;
  assign w_ovf_ev = push && !pop && w_full;
  assign w_unf_ev = pop && w_empty;

  // The slot index is derived from the occupancy count. These indices are only
  // used when the count makes them valid, so the truncation has no effect.
  assign w_top_idx   = AW'(r_count - 1'b1);
  assign w_below_idx = AW'(r_count - CW'(2));
  assign w_wr_idx    = w_push ? AW'(r_count) : w_top_idx;

  // NOTE: every combinational output gets a default value first, so that no
  // path through the block leaves a signal unassigned and infers a latch.
  always_comb begin
    w_count_nxt = r_count;
    w_sp_nxt    = r_sp;
    w_dout_nxt  = r_dout;
    if (w_push) begin
      w_count_nxt = r_count + 1'b1;
      w_sp_nxt    = r_sp - 1'b1;
      w_dout_nxt  = din;
    end else if (w_repl) begin
      w_dout_nxt  = din;
    end else if (w_pop) begin
      w_count_nxt = r_count - 1'b1;
      w_sp_nxt    = r_sp + 1'b1;
      w_dout_nxt  = (r_count == CW'(1)) ? '0 : r_mem[w_below_idx];
    end
  end

  // NOTE: the storage array has no reset. Its contents are don't-care after
  // reset, because the count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (!reset && (w_push || w_repl)) begin
      r_mem[w_wr_idx] <= din;
    end
  end

  // NOTE: sequential state uses non-blocking assignments. This way every
  // register samples the pre-edge values, whatever the order of the
  // statements.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count     <= '0;
      r_sp        <= SP_TOP;
      r_dout      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_sp        <= w_sp_nxt;
      r_dout      <= w_dout_nxt;
      // If an error event happens in the same cycle as clr_err, the event wins.
      r_overflow  <= w_ovf_ev || (r_overflow && !clr_err);
      r_underflow <= w_unf_ev || (r_underflow && !clr_err);
    end
  end

`ifdef STACK_WATERMARK_EN
  logic [CW-1:0] r_hiwater;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hiwater <= '0;
    end else if (clr_err) begin
      r_hiwater <= w_count_nxt;
    end else if (w_count_nxt > r_hiwater) begin
      r_hiwater <= w_count_nxt;
    end
  end

  assign hiwater = r_hiwater;
`endif

  assign dout      = r_dout;
  assign sp        = r_sp;
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_stack_unit.sv
// -----------------------------------------------------------------------------
// tb_stack_unit
// Self-checking bench for stack_unit. It contains a queue-based reference
// model and runs directed scenarios followed by randomised traffic.
// -----------------------------------------------------------------------------
module tb_stack_unit;

  localparam int         WIDTH  = 8;
  localparam int         DEPTH  = 4;
  localparam logic [7:0] SP_TOP = 8'h68;
  localparam int         CW     = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [7:0]    din = '0;
  logic          clr_err = 1'b0;
  logic [7:0]    dout;
  logic [7:0]    sp;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;
`ifdef STACK_WATERMARK_EN
  logic [CW-1:0] hiwater;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a queue whose last element is the top of the stack.
  logic [7:0] m_q[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  int         m_hw = 0;

  stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SP_TOP(SP_TOP)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din),
    .clr_err(clr_err), .dout(dout), .sp(sp), .count(count),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
`ifdef STACK_WATERMARK_EN
    , .hiwater(hiwater)
`endif
  );

  always #5 clk = ~clk;

  // Drives one cycle of stimulus, advances to 1 time unit after the edge and
  // updates the reference model. This task only steps; it does no checking.
  task automatic step(input logic p, input logic po, input logic [7:0] d,
                      input logic c, input logic r);
    logic e, f, ovf_ev, unf_ev;
    push = p; pop = po; din = d; clr_err = c; reset = r;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0; reset = 1'b0;
    if (r) begin
      m_q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_hw = 0;
    end else begin
      e = (m_q.size() == 0);
      f = (m_q.size() == DEPTH);
      ovf_ev = 1'b0; unf_ev = 1'b0;
      if (p && !po) begin
        if (f) ovf_ev = 1'b1; else m_q.push_back(d);
      end else if (po && !p) begin
        if (e) unf_ev = 1'b1; else void'(m_q.pop_back());
      end else if (p && po) begin
        if (e) begin m_q.push_back(d); unf_ev = 1'b1; end
        else m_q[m_q.size()-1] = d;
      end
      m_ovf = ovf_ev | (m_ovf & ~c);
      m_unf = unf_ev | (m_unf & ~c);
      if (c) m_hw = m_q.size();
      else if (m_q.size() > m_hw) m_hw = m_q.size();
    end
  endtask

  task automatic test_reset;
    step(0, 0, 8'h00, 0, 1);
    step(0, 0, 8'h00, 0, 0);
    step(0, 0, 8'h00, 0, 0);
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", count); end
    vectors++; if (sp !== 8'h68) begin miscompares++; $display("FAIL reset_sp got=%h exp=68", sp); end
    vectors++; if (dout !== 8'h00) begin miscompares++; $display("FAIL reset_dout got=%h exp=00", dout); end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got=%b exp=1", empty); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full got=%b exp=0", full); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
  endtask

  task automatic test_fill_drain;
    logic [7:0] pushes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] pops   [4] = '{8'h33, 8'h22, 8'h11, 8'h00};
    for (int i = 0; i < 4; i++) begin
      step(1, 0, pushes[i], 0, 0);
      vectors++;
      if (dout !== pushes[i]) begin miscompares++; $display("FAIL push_dout[%0d] got=%h exp=%h", i, dout, pushes[i]); end
    end
    vectors++; if (sp !== 8'h64) begin miscompares++; $display("FAIL full_sp got=%h exp=64", sp); end
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL full_count got=%0d exp=4", count); end
    vectors++; if (full !== 1'b1 || empty !== 1'b0) begin miscompares++; $display("FAIL full_flag got full=%b empty=%b exp 1/0", full, empty); end
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 8'h00, 0, 0);
      vectors++;
      if (dout !== pops[i]) begin miscompares++; $display("FAIL pop_dout[%0d] got=%h exp=%h", i, dout, pops[i]); end
    end
    vectors++; if (sp !== 8'h68) begin miscompares++; $display("FAIL drain_sp got=%h exp=68", sp); end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL drain_empty got=%b exp=1", empty); end
    vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL drain_underflow got=%b exp=0", underflow); end
  endtask

  task automatic test_overflow;
    step(1, 0, 8'h11, 0, 0);
    step(1, 0, 8'h22, 0, 0);
    step(1, 0, 8'h33, 0, 0);
    step(1, 0, 8'h44, 0, 0);
    step(1, 0, 8'h55, 0, 0);
    vectors++; if (dout !== 8'h44) begin miscompares++; $display("FAIL ovf_dout got=%h exp=44", dout); end
    vectors++; if (sp !== 8'h64) begin miscompares++; $display("FAIL ovf_sp got=%h exp=64", sp); end
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL ovf_count got=%0d exp=4", count); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    step(0, 0, 8'h00, 0, 0);
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    step(0, 0, 8'h00, 1, 0);
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    // An error event in the same cycle as clr_err wins over the clear.
    step(1, 0, 8'h66, 1, 0);
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_vs_clr got=%b exp=1", overflow); end
    step(0, 0, 8'h00, 1, 0);
  endtask

  task automatic test_underflow;
    step(0, 0, 8'h00, 0, 1);
    step(0, 1, 8'h00, 0, 0);
    vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL unf_flag got=%b exp=1", underflow); end
    vectors++; if (count !== 3'd0 || sp !== 8'h68) begin miscompares++; $display("FAIL unf_state got count=%0d sp=%h exp 0/68", count, sp); end
    step(1, 1, 8'hA5, 0, 0);
    vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL pp_empty_count got=%0d exp=1", count); end
    vectors++; if (dout !== 8'hA5) begin miscompares++; $display("FAIL pp_empty_dout got=%h exp=a5", dout); end
    vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL pp_empty_unf got=%b exp=1", underflow); end
  endtask

  task automatic test_replace;
    step(0, 0, 8'h00, 0, 1);
    step(1, 0, 8'h11, 0, 0);
    step(1, 0, 8'h22, 0, 0);
    step(1, 1, 8'h99, 0, 0);
    vectors++; if (count !== 3'd2 || sp !== 8'h66) begin miscompares++; $display("FAIL repl_state got count=%0d sp=%h exp 2/66", count, sp); end
    vectors++; if (dout !== 8'h99) begin miscompares++; $display("FAIL repl_dout got=%h exp=99", dout); end
    vectors++; if (underflow !== 1'b0 || overflow !== 1'b0) begin miscompares++; $display("FAIL repl_flags got ovf=%b unf=%b exp 0/0", overflow, underflow); end
    step(0, 1, 8'h00, 0, 0);
    vectors++; if (dout !== 8'h11) begin miscompares++; $display("FAIL repl_lower got=%h exp=11", dout); end
    // A replace-top on a full stack is also legal and sets no flag.
    step(1, 0, 8'h22, 0, 0);
    step(1, 0, 8'h33, 0, 0);
    step(1, 0, 8'h44, 0, 0);
    step(1, 1, 8'hBE, 0, 0);
    vectors++; if (dout !== 8'hBE || count !== 3'd4 || overflow !== 1'b0) begin miscompares++; $display("FAIL repl_full got dout=%h count=%0d ovf=%b exp be/4/0", dout, count, overflow); end
    step(0, 1, 8'h00, 0, 0);
    vectors++; if (dout !== 8'h33) begin miscompares++; $display("FAIL repl_full_lower got=%h exp=33", dout); end
  endtask

  task automatic test_reset_mid;
    step(1, 0, 8'h77, 0, 0);
    step(1, 0, 8'h78, 0, 1);
    vectors++; if (count !== 3'd0 || sp !== 8'h68 || dout !== 8'h00) begin miscompares++; $display("FAIL rst_mid got count=%0d sp=%h dout=%h exp 0/68/00", count, sp, dout); end
    vectors++; if (empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin miscompares++; $display("FAIL rst_mid_flags got empty=%b ovf=%b unf=%b exp 1/0/0", empty, overflow, underflow); end
`ifdef STACK_WATERMARK_EN
    vectors++; if (hiwater !== 3'd0) begin miscompares++; $display("FAIL hw_reset got=%0d exp=0", hiwater); end
    step(1, 0, 8'h01, 0, 0);
    step(1, 0, 8'h02, 0, 0);
    step(1, 0, 8'h03, 0, 0);
    step(0, 1, 8'h00, 0, 0);
    step(0, 1, 8'h00, 0, 0);
    vectors++; if (hiwater !== 3'd3) begin miscompares++; $display("FAIL hw_peak got=%0d exp=3", hiwater); end
    step(0, 0, 8'h00, 1, 0);
    vectors++; if (hiwater !== 3'd1) begin miscompares++; $display("FAIL hw_clr got=%0d exp=1", hiwater); end
`endif
  endtask

  task automatic test_random;
    logic [22:0] exp_v, got_v;
    logic [7:0]  top;
    int          n;
    step(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
      n = m_q.size();
      top = (n == 0) ? 8'h00 : m_q[n-1];
      exp_v = {top, SP_TOP - 8'(n), 3'(n), (n == 0), (n == DEPTH), m_ovf, m_unf};
      got_v = {dout, sp, count, empty, full, overflow, underflow};
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL rand[%0d] got dout=%h sp=%h cnt=%0d e=%b f=%b o=%b u=%b exp dout=%h sp=%h cnt=%0d e=%b f=%b o=%b u=%b",
                 i, dout, sp, count, empty, full, overflow, underflow,
                 exp_v[22:15], exp_v[14:7], exp_v[6:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
      end
`ifdef STACK_WATERMARK_EN
      vectors++;
      if (hiwater !== 3'(m_hw)) begin miscompares++; $display("FAIL rand_hw[%0d] got=%0d exp=%0d", i, hiwater, m_hw); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_replace();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
